// File: rtl/adc_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_display_scan_ctrl
// Purpose  : Round-robin sequencer between a shared 4-bit ADC sampler and a
//            3-digit multiplexed 7-segment display. For each channel it runs
//            a req/ack handshake with a timeout, then shows the value for a
//            dwell period. Digits show channel index, tens and units.
// Options  : SCAN_HOLD_EN adds a hold input that pins the current channel
//            at the end of the dwell period.
// Revision : 1.0 - initial release
// ============================================================================
module adc_display_scan_ctrl #(
  parameter int NCH     = 4,
  parameter int DWELL   = 50000000,
  parameter int REFRESH = 100000,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
`ifdef SCAN_HOLD_EN
  input  logic       hold,
`endif
  input  logic       adc_ack,
  input  logic [3:0] adc_data,
  output logic [2:0] adc_sel,
  output logic       adc_req,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err
);

  localparam int c_dw_w = $clog2(DWELL);
  localparam int c_to_w = $clog2(TIMEOUT + 1);
  localparam int c_rf_w = $clog2(REFRESH + 1);

  localparam logic [6:0] c_blank = 7'h7F;
  localparam logic [6:0] c_dash  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SHOW = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic [3:0]          value_q, value_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic [2:0]          sel_q, sel_d;
  logic [c_to_w-1:0]   to_cnt_q, to_cnt_d;
  logic [c_dw_w-1:0]   dw_cnt_q, dw_cnt_d;
  logic [c_rf_w-1:0]   rf_cnt_q, rf_cnt_d;
  logic [1:0]          digit_q, digit_d;
  logic [6:0]          seg_q, seg_d;
  logic [2:0]          an_q, an_d;
  logic                hold_in;
  logic [3:0]          units;

`ifdef SCAN_HOLD_EN
  assign hold_in = hold;
`else
  assign hold_in = 1'b0;
`endif

  // Decimal digit to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = c_blank;
    endcase
  endfunction

  // State and datapath registers; async reset drops the request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      sel_q    <= '0;
      to_cnt_q <= '0;
      dw_cnt_q <= '0;
      rf_cnt_q <= '0;
      digit_q  <= '0;
      seg_q    <= c_blank;
      an_q     <= 3'b111;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      to_cnt_q <= to_cnt_d;
      dw_cnt_q <= dw_cnt_d;
      rf_cnt_q <= rf_cnt_d;
      digit_q  <= digit_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  // Handshake / dwell sequencer: next state and registered sampler outputs.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    value_d  = value_q;
    valid_d  = valid_q;
    err_d    = err_q;
    req_d    = req_q;
    sel_d    = sel_q;
    to_cnt_d = to_cnt_q;
    dw_cnt_d = dw_cnt_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = REQ;
      end
      REQ: begin
        req_d    = 1'b1;
        sel_d    = ch_q;
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        // An ack on the same edge as the timeout takes priority.
        if (adc_ack) begin
          value_d  = adc_data;
          valid_d  = 1'b1;
          err_d    = 1'b0;
          req_d    = 1'b0;
          to_cnt_d = '0;
          dw_cnt_d = '0;
          state_d  = SHOW;
        end else if (to_cnt_q == c_to_w'(TIMEOUT - 1)) begin
          valid_d  = 1'b0;
          err_d    = 1'b1;
          req_d    = 1'b0;
          to_cnt_d = '0;
          dw_cnt_d = '0;
          state_d  = SHOW;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (dw_cnt_q == c_dw_w'(DWELL - 1)) begin
          dw_cnt_d = '0;
          if (hold_in) begin
            state_d = REQ;
          end else begin
            ch_d    = (ch_q == 3'(NCH - 1)) ? 3'd0 : ch_q + 3'd1;
            state_d = en ? REQ : IDLE;
          end
        end else begin
          dw_cnt_d = dw_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign units = (value_d >= 4'd10) ? (value_d - 4'd10) : value_d;

  // Digit scan: rotate the lit digit and load its segments on the same edge.
  always_comb begin
    rf_cnt_d = rf_cnt_q;
    digit_d  = digit_q;
    an_d     = 3'b111;
    seg_d    = c_blank;
    if (state_d == IDLE) begin
      rf_cnt_d = '0;
      digit_d  = '0;
    end else begin
      if (state_q == IDLE) begin
        rf_cnt_d = '0;
        digit_d  = '0;
      end else if (rf_cnt_q == c_rf_w'(REFRESH - 1)) begin
        rf_cnt_d = '0;
        digit_d  = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
      end else begin
        rf_cnt_d = rf_cnt_q + 1'b1;
      end
      case (digit_d)
        2'd0: begin
          an_d  = 3'b110;
          seg_d = (!valid_d || err_d) ? c_dash : glyph(units);
        end
        2'd1: begin
          an_d  = 3'b101;
          seg_d = (!valid_d || err_d) ? c_dash :
                  (value_d >= 4'd10)  ? glyph(4'd1) : c_blank;
        end
        default: begin
          an_d  = 3'b011;
          seg_d = glyph({1'b0, ch_d});
        end
      endcase
    end
  end

  assign adc_sel = sel_q;
  assign adc_req = req_q;
  assign seg     = seg_q;
  assign an      = an_q;
  assign err     = err_q;

endmodule
`default_nettype wire
